// File: rtl/sys_timer.sv
// sys_timer: memory-mapped 64-bit RISC-V machine timer (mtime/mtimecmp) on the
// register-interface bus. It provides a torn-read-safe 64-bit readout through a
// high-word shadow and a level timer interrupt.
// Optional feature macro: SYS_TIMER_PRESCALER_EN. When it is defined, a
// programmable prescaler sets the tick rate. When it is undefined, mtime
// advances on every enabled cycle.
// The bus types default to a local package that matches the SoC register
// interface layout. In the SoC they are overridden with core_v_mcu_pkg types.

package sys_timer_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module sys_timer #(
    parameter type         reg_req_t      = sys_timer_pkg::reg_req_t,
    parameter type         reg_rsp_t      = sys_timer_pkg::reg_rsp_t,
    parameter int unsigned PrescalerWidth = 16
) (
    input  logic     clk_i,
    input  logic     rst_ni,
    input  reg_req_t reg_req_i,
    output reg_rsp_t reg_rsp_o,
    output logic     timer_irq_o
);

    // Bus handshake: ready is high in every cycle out of reset. Each access
    // completes in the cycle its valid is high. Read data and error are
    // combinational in that cycle. Writes commit at the following rising edge.

    localparam logic [2:0] IdxCtrl     = 3'd0;
    localparam logic [2:0] IdxPrescale = 3'd1;
    localparam logic [2:0] IdxMtimeLo  = 3'd2;
    localparam logic [2:0] IdxMtimeHi  = 3'd3;
    localparam logic [2:0] IdxCmpLo    = 3'd4;
    localparam logic [2:0] IdxCmpHi    = 3'd5;
    localparam logic [2:0] IdxStatus   = 3'd6;

    logic        ctrl_en;
    logic        ctrl_irq_en;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] shadow;
    logic        expired_q;
    logic        irq_q;
    logic        tick;
    logic [31:0] prescale_rd;

    logic [2:0]  idx;
    logic        access_err;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] rdata;

    // Only addr[4:0] is decoded. The upper address bits are ignored.
    logic unused_addr;
    assign unused_addr = ^reg_req_i.addr[31:5];

    // Byte-lane merge of write data into an existing 32-bit register value.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

    assign idx        = reg_req_i.addr[4:2];
    // Slot 7 (0x1C-0x1F), misaligned offsets and STATUS writes are rejected.
    assign access_err = reg_req_i.valid &&
                        ((reg_req_i.addr[1:0] != 2'b00) ||
                         (idx == 3'd7) ||
                         (reg_req_i.write && (idx == IdxStatus)));
    assign wr_en      = reg_req_i.valid &&  reg_req_i.write && !access_err;
    assign rd_en      = reg_req_i.valid && !reg_req_i.write && !access_err;

`ifdef SYS_TIMER_PRESCALER_EN
    logic [PrescalerWidth-1:0] prescale;
    logic [PrescalerWidth-1:0] pcnt;
    logic [31:0]               prescale_wr;

    assign prescale_rd = 32'(prescale);
    assign prescale_wr = merge_bytes(prescale_rd, reg_req_i.wdata, reg_req_i.wstrb);
    assign tick        = ctrl_en && (pcnt == prescale);

    // PRESCALE register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prescale <= '0;
        end else if (wr_en && (idx == IdxPrescale)) begin
            prescale <= prescale_wr[PrescalerWidth-1:0];
        end
    end

    // Prescale counter. A CTRL or PRESCALE write restarts it so the next tick
    // lands exactly PRESCALE+1 cycles later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt <= '0;
        end else if (wr_en && ((idx == IdxCtrl) || (idx == IdxPrescale))) begin
            pcnt <= '0;
        end else if (ctrl_en) begin
            if (pcnt == prescale) pcnt <= '0;
            else                  pcnt <= pcnt + PrescalerWidth'(1);
        end
    end
`else
    // Without the prescaler, PRESCALE reads as zero, writes to it are
    // accepted and ignored, and mtime ticks on every enabled cycle.
    localparam int unsigned unused_prescaler_width = PrescalerWidth;
    assign prescale_rd = 32'd0;
    assign tick        = ctrl_en;
`endif

    // CTRL register. Only the enable and irq_en bits exist.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
        end else if (wr_en && (idx == IdxCtrl) && reg_req_i.wstrb[0]) begin
            ctrl_en     <= reg_req_i.wdata[0];
            ctrl_irq_en <= reg_req_i.wdata[1];
        end
    end

    // mtime counter. A software write to either half wins over that cycle's tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtime <= 64'd0;
        end else if (wr_en && (idx == IdxMtimeLo)) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], reg_req_i.wdata, reg_req_i.wstrb);
        end else if (wr_en && (idx == IdxMtimeHi)) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], reg_req_i.wdata, reg_req_i.wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // mtimecmp register. It resets to all ones so the timer cannot fire by accident.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mtimecmp <= '1;
        end else if (wr_en && (idx == IdxCmpLo)) begin
            mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], reg_req_i.wdata, reg_req_i.wstrb);
        end else if (wr_en && (idx == IdxCmpHi)) begin
            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], reg_req_i.wdata, reg_req_i.wstrb);
        end
    end

    // High-word shadow. A read of MTIME_LO captures the matching high word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shadow <= 32'd0;
        end else if (rd_en && (idx == IdxMtimeLo)) begin
            shadow <= mtime[63:32];
        end
    end

    // Registered compare, then registered interrupt level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            expired_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            expired_q <= (mtime >= mtimecmp);
            irq_q     <= ctrl_irq_en & expired_q;
        end
    end

    assign timer_irq_o = irq_q;

    // Read data mux. It returns zero for idle cycles and rejected accesses.
    always_comb begin
        rdata = 32'd0;
        if (rd_en) begin
            case (idx)
                IdxCtrl:     rdata = {30'd0, ctrl_irq_en, ctrl_en};
                IdxPrescale: rdata = prescale_rd;
                IdxMtimeLo:  rdata = mtime[31:0];
                IdxMtimeHi:  rdata = shadow;
                IdxCmpLo:    rdata = mtimecmp[31:0];
                IdxCmpHi:    rdata = mtimecmp[63:32];
                IdxStatus:   rdata = {31'd0, expired_q};
                default:     rdata = 32'd0;
            endcase
        end
    end

    // Response. It is held all-zero while reset is asserted.
    always_comb begin
        reg_rsp_o       = '0;
        reg_rsp_o.ready = rst_ni;
        reg_rsp_o.error = rst_ni & access_err;
        reg_rsp_o.rdata = rst_ni ? rdata : 32'd0;
    end

endmodule

// File: tb/tb_sys_timer.sv
// Directed testbench for sys_timer. The expected values are hand-computed
// from the register map and timing rules. Build it with or without
// SYS_TIMER_PRESCALER_EN.
module tb_sys_timer;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_PRESC  = 32'h04;
    localparam logic [31:0] A_MTLO   = 32'h08;
    localparam logic [31:0] A_MTHI   = 32'h0C;
    localparam logic [31:0] A_CMPLO  = 32'h10;
    localparam logic [31:0] A_CMPHI  = 32'h14;
    localparam logic [31:0] A_STATUS = 32'h18;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    sys_timer_pkg::reg_req_t req;
    sys_timer_pkg::reg_rsp_t rsp;
    logic timer_irq;

    int n_checks = 0;
    int n_pass   = 0;
    logic [63:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    sys_timer dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .reg_req_i   (req),
        .reg_rsp_o   (rsp),
        .timer_irq_o (timer_irq)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // driver tasks
    task automatic bus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, output logic [31:0] rdata, output logic err);
        @(negedge clk);
        req.valid = 1'b1;
        req.write = wr;
        req.addr  = addr;
        req.wdata = wdata;
        req.wstrb = strb;
        #1;
        rdata = rsp.rdata;
        err   = rsp.error;
        @(posedge clk);
        #1;
        req = '0;
    endtask

    task automatic reg_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        logic err;
        bus(1'b1, addr, data, 4'hF, rd, err);
    endtask

    task automatic reg_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic err;
        exp_q.push_back({32'd0, exp});
        bus(1'b0, addr, 32'd0, 4'h0, rd, err);
        check(tag, {32'd0, rd}, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        req = '0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rd;
        logic err;
        int first;

        req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // basic count with PRESCALE = 0
        reg_write(A_PRESC, 32'd0);
        reg_write(A_CTRL, 32'd1);
        idle(10);
        reg_read("basic_lo", A_MTLO, 32'd10);
        reg_read("basic_hi", A_MTHI, 32'd0);
        @(negedge clk);
        check("idle_rdata", {32'd0, rsp.rdata}, 64'd0);

        // prescaler
        do_reset();
        reg_write(A_PRESC, 32'd3);
        reg_write(A_CTRL, 32'd1);
        idle(40);
`ifdef SYS_TIMER_PRESCALER_EN
        reg_read("presc_mtime", A_MTLO, 32'd10);
        reg_read("presc_reg", A_PRESC, 32'd3);
`else
        reg_read("presc_mtime", A_MTLO, 32'd40);
        reg_read("presc_reg", A_PRESC, 32'd0);
`endif

        // carry across the 32-bit boundary and shadowed high-word read
        do_reset();
        reg_write(A_PRESC, 32'd0);
        reg_write(A_MTHI, 32'd0);
        reg_write(A_MTLO, 32'hFFFF_FFFE);
        reg_write(A_CTRL, 32'd1);
        reg_read("carry_lo0", A_MTLO, 32'hFFFF_FFFE);
        idle(1);
        reg_read("carry_hi0", A_MTHI, 32'd0);
        reg_read("carry_lo1", A_MTLO, 32'd1);
        reg_read("carry_hi1", A_MTHI, 32'd1);

        // error responses, with state left unchanged
        do_reset();
        bus(1'b0, 32'h1C, 32'd0, 4'h0, rd, err);
        check("err_rd_1c", {63'd0, err}, 64'd1);
        check("err_rd_1c_data", {32'd0, rd}, 64'd0);
        bus(1'b1, A_STATUS, 32'd1, 4'hF, rd, err);
        check("err_wr_status", {63'd0, err}, 64'd1);
        bus(1'b1, 32'h02, 32'd3, 4'hF, rd, err);
        check("err_wr_02", {63'd0, err}, 64'd1);
        bus(1'b1, 32'h0A, 32'd5, 4'hF, rd, err);
        check("err_wr_0a", {63'd0, err}, 64'd1);
        reg_read("err_ctrl_kept", A_CTRL, 32'd0);
        reg_read("err_mtlo_kept", A_MTLO, 32'd0);
        reg_read("err_status_kept", A_STATUS, 32'd0);
        bus(1'b0, A_PRESC, 32'd0, 4'h0, rd, err);
        check("ok_rd_presc", {63'd0, err}, 64'd0);
        bus(1'b1, A_CMPLO, 32'hAABB_CCDD, 4'b0101, rd, err);
        reg_read("wstrb_cmplo", A_CMPLO, 32'hFFBB_FFDD);

        // wrap of mtime with mtimecmp = 0
        do_reset();
        reg_write(A_CMPLO, 32'd0);
        reg_write(A_CMPHI, 32'd0);
        reg_write(A_MTLO, 32'hFFFF_FFFF);
        reg_write(A_MTHI, 32'hFFFF_FFFF);
        reg_read("wrap_status0", A_STATUS, 32'd1);
        reg_write(A_CTRL, 32'd1);
        reg_read("wrap_lo0", A_MTLO, 32'hFFFF_FFFF);
        reg_read("wrap_hi0", A_MTHI, 32'hFFFF_FFFF);
        reg_read("wrap_lo1", A_MTLO, 32'd1);
        reg_read("wrap_hi1", A_MTHI, 32'd0);
        reg_read("wrap_status1", A_STATUS, 32'd1);

        // interrupt rise and clear latency
        do_reset();
        reg_write(A_CMPHI, 32'd0);
        reg_write(A_CMPLO, 32'd20);
        reg_write(A_PRESC, 32'd0);
        reg_write(A_CTRL, 32'd3);
        first = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #1;
            if (timer_irq && (first == 0)) first = k;
        end
        check("irq_rise_edge", 64'(first), 64'd22);
        reg_read("irq_status", A_STATUS, 32'd1);
        reg_write(A_CMPLO, 32'hFFFF_FFFF);
        check("irq_clr_e0", {63'd0, timer_irq}, 64'd1);
        @(posedge clk);
        #1;
        check("irq_clr_e1", {63'd0, timer_irq}, 64'd1);
        @(posedge clk);
        #1;
        check("irq_clr_e2", {63'd0, timer_irq}, 64'd0);

        // asynchronous reset mid-count while the interrupt is high
        reg_write(A_CMPLO, 32'd0);
        idle(3);
        #1;
        check("irq_before_rst", {63'd0, timer_irq}, 64'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_irq_now", {63'd0, timer_irq}, 64'd0);
        check("rst_rsp_zero", 64'(rsp), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        reg_read("rst_ctrl", A_CTRL, 32'd0);
        reg_read("rst_presc", A_PRESC, 32'd0);
        reg_read("rst_mtlo", A_MTLO, 32'd0);
        reg_read("rst_mthi", A_MTHI, 32'd0);
        reg_read("rst_cmplo", A_CMPLO, 32'hFFFF_FFFF);
        reg_read("rst_cmphi", A_CMPHI, 32'hFFFF_FFFF);
        reg_read("rst_status", A_STATUS, 32'd0);
        check("rst_irq_after", {63'd0, timer_irq}, 64'd0);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sys_timer.md
# sys_timer

Memory-mapped 64-bit machine timer on the peripheral register bus. It produces the machine timer interrupt that drives `time_irq_i` of `cpu_subsystem`, which is currently tied to zero. It occupies one register-interface slave slot alongside `soc_ctrl` and `fast_intr_ctrl`. It implements RISC-V `mtime`/`mtimecmp` semantics, an optional prescaler, and a torn-read-safe 64-bit readout.

## Interface
- `reg_req_t`, default `core_v_mcu_pkg::reg_req_t`: register-interface request type (fields `valid`, `write`, `addr`, `wdata`, `wstrb`).
- `reg_rsp_t`, default `core_v_mcu_pkg::reg_rsp_t`: response type (fields `ready`, `rdata`, `error`).
- `PrescalerWidth`, default 16: width of the PRESCALE register, range 1..32.
- `clk_i`, input, 1: the block's single clock.
- `rst_ni`, input, 1: reset, asynchronous and active-low.
- `reg_req_i`, input, `reg_req_t`: register bus request.
- `reg_rsp_o`, output, `reg_rsp_t`: register bus response.
- `timer_irq_o`, output, 1: level machine timer interrupt to the CPU.

## Operation
- Register map uses byte offsets and only `addr[4:0]`; all registers are 32 bits.
  - 0x00 CTRL: bit0 `en`, bit1 `irq_en`.
  - 0x04 PRESCALE.
  - 0x08 MTIME_LO; 0x0C MTIME_HI.
  - 0x10 MTIMECMP_LO; 0x14 MTIMECMP_HI.
  - 0x18 STATUS (read-only): bit0 `expired`, which is `mtime >= mtimecmp` taken from the registered compare.
- Reset values:
  - CTRL = 0; PRESCALE = 0; mtime = 0.
  - mtimecmp = all ones.
  - Read shadow = 0.
  - `timer_irq_o` = 0.
  - `reg_rsp_o` = all zero.
- Bus handshake:
  - `ready` = 1 combinationally in every cycle; every access completes in the cycle `valid` is high.
  - `error` = 1 for offsets 0x1C–0x1F, for any non-word-aligned `addr[1:0]`, and for writes to STATUS. Erroneous writes change no state.
  - Writes honour `wstrb` per byte. Unused CTRL bits read 0.
  - With `valid` = 0, `rdata` = 0.
- Tick generation: the prescale counter `pcnt` runs while `en` = 1.
  - When `pcnt == PRESCALE`, the counter asserts `tick` and wraps to 0; otherwise it increments.
  - The tick period is therefore PRESCALE+1 cycles, and PRESCALE = 0 gives a tick every cycle.
  - Writing CTRL or PRESCALE clears `pcnt` to 0.
  - `en` = 0 holds both `pcnt` and mtime.
- mtime increments by 1 on each `tick` and wraps from 2^64−1 to 0.
  - A write to MTIME_LO or MTIME_HI in the same cycle as a tick takes priority: the written half takes the write data, the other half holds, and no increment is applied that cycle.
- Atomic read:
  - Reading MTIME_LO returns the live low word and latches the live `mtime[63:32]` into the shadow.
  - Reading MTIME_HI returns the shadow, so software reads LO then HI.
  - Writes never touch the shadow.
- Compare: the registered flag `expired_q <= (mtime >= mtimecmp)` is evaluated every cycle on current register values, unsigned 64-bit.
- Interrupt: `timer_irq_o` is the registered value of `irq_en & expired_q`. It is level-sensitive and software clears it by raising mtimecmp or clearing `irq_en`.
- A reset asserted mid-operation returns all state to the reset values asynchronously; `timer_irq_o` drops immediately.

## Timing
- Read data is combinational and appears in the same cycle as `valid`.
- A write takes effect at the next rising edge.
- Latency from mtime reaching mtimecmp (register update at edge N) to:
  - `expired_q` = 1: edge N+1.
  - `timer_irq_o` = 1: edge N+2.
- Clearing the condition by a write at edge N deasserts `timer_irq_o` at edge N+2.
- The first tick after `en` 0→1 written at edge N occurs at edge N+1+PRESCALE. The first increment is visible after that edge.

## Configuration
- `SYS_TIMER_PRESCALER_EN`
  - Defined: the prescaler operates as described above.
  - Undefined: no prescaler logic is built and `tick` = `en` every cycle. PRESCALE reads 0, writes to it are accepted without error and ignored, and CTRL writes have no counter side effect.

## Test plan
- Reset: assert `rst_ni` = 0 mid-count → all registers read reset values and `timer_irq_o` = 0 within the same cycle.
- Basic count: PRESCALE = 0, CTRL = 1, idle 10 cycles → MTIME_LO = 10 (±1 for the read edge), MTIME_HI = 0.
- Prescaler (with macro): PRESCALE = 3, CTRL = 1, idle 40 cycles → mtime = 10; without the macro → mtime = 40 and PRESCALE reads 0.
- Carry/atomic read: MTIME_HI = 0, MTIME_LO = 0xFFFF_FFFE, en = 1, PRESCALE = 0; read LO, then HI two cycles later → HI equals the value latched with LO (0, or 1 if LO read 0x0000_0000), never torn.
- Interrupt: mtimecmp = 20, CTRL = 3 from mtime = 0 → `timer_irq_o` rises exactly 2 cycles after mtime = 20. Writing MTIMECMP_LO = 0xFFFF_FFFF (HI = 0) then makes mtime < cmp → irq falls 2 cycles after the write.
- Errors: read offset 0x1C, write STATUS, and write offset 0x02 → `error` = 1 on each, and no register changes; mtimecmp wrap test: mtime = 2^64−1 with cmp = 0 → `expired` = 1, then mtime wraps to 0 and `expired` stays 1.
